// File: rtl/overlay_pkg.sv
// Shared widths, slot count and marker colours for the centroid overlay.
package overlay_pkg;

  localparam int TRK_X_W   = 9;
  localparam int TRK_Y_W   = 8;
  localparam int VID_X_W   = 11;
  localparam int VID_Y_W   = 10;
  localparam int MAX_BALLS = 7;
  localparam int IDX_W     = 3;
  localparam int PIX_W     = 24;

  localparam logic [PIX_W-1:0] PALETTE [MAX_BALLS] = '{
    24'hFF0000,  // red
    24'h00FF00,  // green
    24'h0000FF,  // blue
    24'hFFFF00,  // yellow
    24'h00FFFF,  // cyan
    24'hFF00FF,  // magenta
    24'hFFFFFF   // white
  };

  typedef logic [MAX_BALLS-1:0][TRK_X_W-1:0] bank_x_t;
  typedef logic [MAX_BALLS-1:0][TRK_Y_W-1:0] bank_y_t;

  function automatic logic [IDX_W-1:0] sat_count(input logic [IDX_W-1:0] n);
    return ({1'b0, n} > (IDX_W+1)'(MAX_BALLS)) ? IDX_W'(MAX_BALLS) : n;
  endfunction

endpackage

// File: rtl/centroid_overlay_if.sv
// Tracker results plus video in/out signals of the centroid overlay.
interface centroid_overlay_if;
  import overlay_pkg::*;

  bank_x_t            centroids_x_in;
  bank_y_t            centroids_y_in;
  logic [IDX_W-1:0]   num_balls_in;
  logic               centroids_valid_in;
  logic               new_frame_in;
  logic [VID_X_W-1:0] hcount_in;
  logic [VID_Y_W-1:0] vcount_in;
  logic [PIX_W-1:0]   pixel_in;
  logic               pixel_valid_in;
  logic [PIX_W-1:0]   pixel_out;
  logic               hit_out;
  logic [IDX_W-1:0]   hit_index_out;
  logic               pixel_valid_out;
  logic [IDX_W-1:0]   shown_count_out;

  modport master (
    output centroids_x_in, centroids_y_in, num_balls_in, centroids_valid_in,
           new_frame_in, hcount_in, vcount_in, pixel_in, pixel_valid_in,
    input  pixel_out, hit_out, hit_index_out, pixel_valid_out, shown_count_out
  );

  modport slave (
    input  centroids_x_in, centroids_y_in, num_balls_in, centroids_valid_in,
           new_frame_in, hcount_in, vcount_in, pixel_in, pixel_valid_in,
    output pixel_out, hit_out, hit_index_out, pixel_valid_out, shown_count_out
  );

endinterface

// File: rtl/marker_hit.sv
// Single-slot marker hit test in tracker coordinates (Chebyshev distance box).
module marker_hit
  import overlay_pkg::*;
#(
  parameter int MARKER_HALF = 3,
  parameter int FILLED      = 0
) (
  input  logic [VID_X_W-1:0] px,
  input  logic [VID_X_W-1:0] py,
  input  logic [TRK_X_W-1:0] cx,
  input  logic [TRK_Y_W-1:0] cy,
  output logic               hit
);

  localparam logic [VID_X_W-1:0] HALF = VID_X_W'(MARKER_HALF);

  logic [VID_X_W-1:0] cx_w, cy_w, dx, dy, dmax;

  // Compare-and-subtract keeps the distance unsigned without wrap-around.
  always_comb begin
    cx_w = VID_X_W'(cx);
    cy_w = VID_X_W'(cy);
    dx   = (px >= cx_w) ? (px - cx_w) : (cx_w - px);
    dy   = (py >= cy_w) ? (py - cy_w) : (cy_w - py);
    dmax = (dx >= dy) ? dx : dy;
    hit  = (dmax <= HALF) && ((FILLED != 0) || (dmax == HALF));
  end

endmodule

// File: rtl/centroid_overlay.sv
// Latches tracker centroids, promotes them at frame boundaries and draws
// coloured square markers into the pixel stream with a 2-cycle pipeline.
module centroid_overlay
  import overlay_pkg::*;
#(
  parameter int SCALE_SHIFT = 2,
  parameter int MARKER_HALF = 3,
  parameter int FILLED      = 0
) (
  input  logic              clk_in,
  input  logic              rst_in,
  centroid_overlay_if.slave bus
);

  logic             valid_q;
  logic             pending_full;
  bank_x_t          pend_x, disp_x;
  bank_y_t          pend_y, disp_y;
  logic [IDX_W-1:0] pend_n, shown_n;
  logic             capture, promote;

  assign capture = bus.centroids_valid_in & ~valid_q;
  assign promote = bus.new_frame_in & pending_full;

  // Promotion reads pending before a same-cycle capture overwrites it.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid_q      <= 1'b0;
      pending_full <= 1'b0;
      pend_x       <= '0;
      pend_y       <= '0;
      pend_n       <= '0;
      disp_x       <= '0;
      disp_y       <= '0;
      shown_n      <= '0;
    end else begin
      valid_q <= bus.centroids_valid_in;
      if (promote) begin
        disp_x  <= pend_x;
        disp_y  <= pend_y;
        shown_n <= pend_n;
      end
      if (capture) begin
        pend_x       <= bus.centroids_x_in;
        pend_y       <= bus.centroids_y_in;
        pend_n       <= sat_count(bus.num_balls_in);
        pending_full <= 1'b1;
      end else if (promote) begin
        pending_full <= 1'b0;
      end
    end
  end

  logic [VID_X_W-1:0]   px, py;
  logic [MAX_BALLS-1:0] slot_hit, hit_vec;

  assign px = bus.hcount_in >> SCALE_SHIFT;
  assign py = VID_X_W'(bus.vcount_in) >> SCALE_SHIFT;

  for (genvar g = 0; g < MAX_BALLS; g++) begin : g_slot
    marker_hit #(
      .MARKER_HALF (MARKER_HALF),
      .FILLED      (FILLED)
    ) u_hit (
      .px  (px),
      .py  (py),
      .cx  (disp_x[g]),
      .cy  (disp_y[g]),
      .hit (slot_hit[g])
    );
  end

  always_comb begin
    hit_vec = '0;
    for (int i = 0; i < MAX_BALLS; i++) begin
      hit_vec[i] = slot_hit[i] && (IDX_W'(i) < shown_n);
    end
  end

  logic [MAX_BALLS-1:0] hit_s1;
  logic [PIX_W-1:0]     pix_s1;
  logic                 pv_s1;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      hit_s1 <= '0;
      pix_s1 <= '0;
      pv_s1  <= 1'b0;
    end else begin
      hit_s1 <= hit_vec;
      pix_s1 <= bus.pixel_in;
      pv_s1  <= bus.pixel_valid_in;
    end
  end

  logic             sel_hit;
  logic [IDX_W-1:0] sel_idx;

  // Scan from the top so the lowest-index hitting slot is the last assignment.
  always_comb begin
    sel_hit = 1'b0;
    sel_idx = '0;
    for (int i = MAX_BALLS - 1; i >= 0; i--) begin
      if (hit_s1[i]) begin
        sel_hit = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      bus.pixel_out       <= '0;
      bus.hit_out         <= 1'b0;
      bus.hit_index_out   <= '0;
      bus.pixel_valid_out <= 1'b0;
    end else begin
      bus.pixel_out       <= sel_hit ? PALETTE[sel_idx] : pix_s1;
      bus.hit_out         <= sel_hit;
      bus.hit_index_out   <= sel_idx;
      bus.pixel_valid_out <= pv_s1;
    end
  end

  assign bus.shown_count_out = shown_n;

endmodule

// File: tb/tb_centroid_overlay.sv
// Self-checking bench for centroid_overlay: directed scenarios plus a random
// pixel stream compared against a frame-level reference model.
module tb_centroid_overlay;

  localparam int SHIFT  = 2;
  localparam int HALF   = 3;
  localparam int FILLED = 0;

  typedef struct packed {
    logic [23:0] pix;
    logic        hit;
    logic [2:0]  idx;
    logic        pv;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  centroid_overlay_if bus();

  centroid_overlay #(
    .SCALE_SHIFT (SHIFT),
    .MARKER_HALF (HALF),
    .FILLED      (FILLED)
  ) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [23:0] pal [7] = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFF00,
                           24'h00FFFF, 24'hFF00FF, 24'hFFFFFF};

  // Model state: what is on screen, what waits for the next frame.
  int   m_disp_x [7];
  int   m_disp_y [7];
  int   m_pend_x [7];
  int   m_pend_y [7];
  int   m_shown, m_pend_n;
  bit   m_pfull, m_prev_valid;
  exp_t q[$];
  exp_t ex;
  bit   exp_ok;

  function automatic int iabs(input int a);
    return (a < 0) ? -a : a;
  endfunction

  function automatic exp_t ref_out(input int h, input int v, input logic [23:0] bg,
                                   input logic pv);
    exp_t e;
    e.pix = bg; e.hit = 1'b0; e.idx = 3'd0; e.pv = pv;
    for (int i = 0; i < m_shown; i++) begin
      int dx, dy, d;
      dx = iabs((h >> SHIFT) - m_disp_x[i]);
      dy = iabs((v >> SHIFT) - m_disp_y[i]);
      d  = (dx > dy) ? dx : dy;
      if (!e.hit && d <= HALF && (FILLED != 0 || d == HALF)) begin
        e.hit = 1'b1; e.idx = 3'(i); e.pix = pal[i];
      end
    end
    return e;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 7; i++) begin
      m_disp_x[i] = 0; m_disp_y[i] = 0; m_pend_x[i] = 0; m_pend_y[i] = 0;
    end
    m_shown = 0; m_pend_n = 0; m_pfull = 0; m_prev_valid = 0;
    q.delete();
    exp_ok = 0;
  endtask

  task automatic tick();
    bit rise, promoted;
    q.push_back(ref_out(int'(bus.hcount_in), int'(bus.vcount_in), bus.pixel_in,
                        bus.pixel_valid_in));
    rise = bus.centroids_valid_in && !m_prev_valid;
    promoted = bus.new_frame_in && m_pfull;
    if (promoted) begin
      m_disp_x = m_pend_x; m_disp_y = m_pend_y; m_shown = m_pend_n; m_pfull = 0;
    end
    if (rise) begin
      for (int i = 0; i < 7; i++) begin
        m_pend_x[i] = int'(bus.centroids_x_in[i]);
        m_pend_y[i] = int'(bus.centroids_y_in[i]);
      end
      m_pend_n = (int'(bus.num_balls_in) > 7) ? 7 : int'(bus.num_balls_in);
      m_pfull  = 1;
    end
    m_prev_valid = bus.centroids_valid_in;
    @(posedge clk); #1;
    exp_ok = 0;
    if (q.size() == 2) begin
      ex = q.pop_front();
      exp_ok = 1;
    end
  endtask

  task automatic load(input int slot, input int x, input int y);
    bus.centroids_x_in[slot] = 9'(x);
    bus.centroids_y_in[slot] = 8'(y);
  endtask

  task automatic capture(input int n);
    bus.num_balls_in = 3'(n);
    bus.centroids_valid_in = 1'b1;
    tick();
    bus.centroids_valid_in = 1'b0;
    tick();
  endtask

  task automatic frame();
    bus.new_frame_in = 1'b1;
    tick();
    bus.new_frame_in = 1'b0;
  endtask

  task automatic show(input int h, input int v, input logic [23:0] bg);
    bus.hcount_in = 11'(h);
    bus.vcount_in = 10'(v);
    bus.pixel_in = bg;
    bus.pixel_valid_in = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    #7;
    n_checks++;
    if (bus.pixel_out !== 24'h0 || bus.hit_out !== 1'b0 || bus.hit_index_out !== 3'd0 ||
        bus.pixel_valid_out !== 1'b0 || bus.shown_count_out !== 3'd0) begin
      n_errors++;
      $display("FAIL reset_outputs got pix=%h hit=%b idx=%0d pv=%b shown=%0d want all 0",
               bus.pixel_out, bus.hit_out, bus.hit_index_out, bus.pixel_valid_out,
               bus.shown_count_out);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    show(100, 100, 24'h123456);
    n_checks++;
    if (!exp_ok || bus.pixel_out !== 24'h123456 || bus.hit_out !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_passthru got pix=%h hit=%b want 123456 hit 0",
               bus.pixel_out, bus.hit_out);
    end
  endtask

  task automatic test_single_capture();
    load(0, 100, 50);
    capture(1);
    frame();
    n_checks++;
    if (bus.shown_count_out !== 3'd1) begin
      n_errors++;
      $display("FAIL single_shown got %0d want 1", bus.shown_count_out);
    end
    show(412, 200, 24'hABCDEF);
    n_checks++;
    if (bus.pixel_out !== 24'hFF0000 || bus.hit_out !== 1'b1 || bus.hit_index_out !== 3'd0) begin
      n_errors++;
      $display("FAIL single_edge got pix=%h hit=%b idx=%0d want FF0000 1 0",
               bus.pixel_out, bus.hit_out, bus.hit_index_out);
    end
    show(400, 200, 24'hABCDEF);
    n_checks++;
    if (bus.pixel_out !== 24'hABCDEF || bus.hit_out !== 1'b0 || bus.hit_index_out !== 3'd0) begin
      n_errors++;
      $display("FAIL single_centre got pix=%h hit=%b idx=%0d want ABCDEF 0 0",
               bus.pixel_out, bus.hit_out, bus.hit_index_out);
    end
  endtask

  task automatic test_tear_free();
    load(0, 200, 90);
    capture(1);
    show(412, 200, 24'h010203);
    n_checks++;
    if (bus.pixel_out !== 24'hFF0000 || bus.hit_out !== 1'b1) begin
      n_errors++;
      $display("FAIL tear_old_still got pix=%h hit=%b want FF0000 1", bus.pixel_out, bus.hit_out);
    end
    show(812, 360, 24'h010203);
    n_checks++;
    if (bus.hit_out !== 1'b0 || bus.pixel_out !== 24'h010203) begin
      n_errors++;
      $display("FAIL tear_new_early got pix=%h hit=%b want 010203 0", bus.pixel_out, bus.hit_out);
    end
    frame();
    show(812, 360, 24'h010203);
    n_checks++;
    if (bus.pixel_out !== 24'hFF0000 || bus.hit_out !== 1'b1) begin
      n_errors++;
      $display("FAIL tear_new_shown got pix=%h hit=%b want FF0000 1", bus.pixel_out, bus.hit_out);
    end
    show(412, 200, 24'h010203);
    n_checks++;
    if (bus.hit_out !== 1'b0) begin
      n_errors++;
      $display("FAIL tear_old_gone got hit=%b want 0", bus.hit_out);
    end
  endtask

  task automatic test_overlap();
    load(0, 60, 60);
    load(1, 60, 60);
    capture(2);
    frame();
    show(252, 240, 24'h000000);
    n_checks++;
    if (bus.hit_index_out !== 3'd0 || bus.pixel_out !== 24'hFF0000 || bus.hit_out !== 1'b1) begin
      n_errors++;
      $display("FAIL overlap_prio got idx=%0d pix=%h hit=%b want 0 FF0000 1",
               bus.hit_index_out, bus.pixel_out, bus.hit_out);
    end
  endtask

  task automatic test_simultaneous();
    bus.num_balls_in = 3'd3;
    bus.centroids_valid_in = 1'b1;
    bus.new_frame_in = 1'b1;
    tick();
    bus.centroids_valid_in = 1'b0;
    bus.new_frame_in = 1'b0;
    n_checks++;
    if (bus.shown_count_out !== 3'd2) begin
      n_errors++;
      $display("FAIL simul_unchanged got %0d want 2", bus.shown_count_out);
    end
    tick();
    frame();
    n_checks++;
    if (bus.shown_count_out !== 3'd3) begin
      n_errors++;
      $display("FAIL simul_next_frame got %0d want 3", bus.shown_count_out);
    end
  endtask

  task automatic test_num_balls();
    for (int i = 0; i < 7; i++) load(i, 300, 170);
    load(4, 10, 10);
    capture(3);
    frame();
    show(52, 40, 24'h777777);
    n_checks++;
    if (bus.hit_out !== 1'b0 || bus.pixel_out !== 24'h777777) begin
      n_errors++;
      $display("FAIL count3_slot4 got pix=%h hit=%b want 777777 0", bus.pixel_out, bus.hit_out);
    end
    capture(7);
    frame();
    show(52, 40, 24'h777777);
    n_checks++;
    if (bus.pixel_out !== 24'h00FFFF || bus.hit_index_out !== 3'd4) begin
      n_errors++;
      $display("FAIL count7_slot4 got pix=%h idx=%0d want 00FFFF 4",
               bus.pixel_out, bus.hit_index_out);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      int s, tx, ty;
      if (!bus.centroids_valid_in && $urandom_range(0, 15) == 0) begin
        for (int i = 0; i < 7; i++) load(i, $urandom_range(0, 319), $urandom_range(0, 179));
        bus.num_balls_in = 3'($urandom_range(0, 7));
        bus.centroids_valid_in = 1'b1;
      end else if (bus.centroids_valid_in && $urandom_range(0, 2) == 0) begin
        bus.centroids_valid_in = 1'b0;
      end
      bus.new_frame_in = ($urandom_range(0, 24) == 0);
      s  = $urandom_range(0, 6);
      tx = m_disp_x[s] + $urandom_range(0, 10) - 5;
      ty = m_disp_y[s] + $urandom_range(0, 10) - 5;
      tx = (tx < 0) ? 0 : (tx > 319) ? 319 : tx;
      ty = (ty < 0) ? 0 : (ty > 179) ? 179 : ty;
      bus.hcount_in = 11'(tx * 4 + $urandom_range(0, 3));
      bus.vcount_in = 10'(ty * 4 + $urandom_range(0, 3));
      bus.pixel_in = 24'($urandom);
      bus.pixel_valid_in = 1'($urandom_range(0, 1));
      tick();
      if (exp_ok) begin
        n_checks++;
        if (bus.pixel_out !== ex.pix || bus.hit_out !== ex.hit ||
            bus.hit_index_out !== ex.idx || bus.pixel_valid_out !== ex.pv) begin
          n_errors++;
          $display("FAIL rand_pixel cyc=%0d got pix=%h hit=%b idx=%0d pv=%b want pix=%h hit=%b idx=%0d pv=%b",
                   c, bus.pixel_out, bus.hit_out, bus.hit_index_out, bus.pixel_valid_out,
                   ex.pix, ex.hit, ex.idx, ex.pv);
        end
      end
      n_checks++;
      if (int'(bus.shown_count_out) != m_shown) begin
        n_errors++;
        $display("FAIL rand_shown cyc=%0d got %0d want %0d", c, bus.shown_count_out, m_shown);
      end
    end
    bus.centroids_valid_in = 1'b0;
    bus.new_frame_in = 1'b0;
    tick();
  endtask

  task automatic test_reset_midframe();
    load(0, 100, 50);
    capture(1);
    frame();
    bus.hcount_in = 11'd412;
    bus.vcount_in = 10'd200;
    tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.pixel_out !== 24'h0 || bus.hit_out !== 1'b0 || bus.pixel_valid_out !== 1'b0 ||
        bus.shown_count_out !== 3'd0) begin
      n_errors++;
      $display("FAIL midreset_clear got pix=%h hit=%b pv=%b shown=%0d want all 0",
               bus.pixel_out, bus.hit_out, bus.pixel_valid_out, bus.shown_count_out);
    end
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
    frame();
    show(412, 200, 24'h445566);
    n_checks++;
    if (bus.hit_out !== 1'b0 || bus.pixel_out !== 24'h445566) begin
      n_errors++;
      $display("FAIL midreset_absent got pix=%h hit=%b want 445566 0", bus.pixel_out, bus.hit_out);
    end
    capture(1);
    frame();
    show(412, 200, 24'h445566);
    n_checks++;
    if (bus.hit_out !== 1'b1 || bus.pixel_out !== 24'hFF0000) begin
      n_errors++;
      $display("FAIL midreset_back got pix=%h hit=%b want FF0000 1", bus.pixel_out, bus.hit_out);
    end
  endtask

  initial begin
    bus.centroids_x_in = '0;
    bus.centroids_y_in = '0;
    bus.num_balls_in = '0;
    bus.centroids_valid_in = 1'b0;
    bus.new_frame_in = 1'b0;
    bus.hcount_in = '0;
    bus.vcount_in = '0;
    bus.pixel_in = '0;
    bus.pixel_valid_in = 1'b0;
    model_clear();
    test_reset();
    test_single_capture();
    test_tear_free();
    test_overlap();
    test_simultaneous();
    test_num_balls();
    test_random();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/centroid_overlay.md
# centroid_overlay

Consumes the centroid results published by the k-means tracker and draws one coloured square marker per tracked ball onto the outgoing 1280x720 video stream. Results are latched on the tracker's valid rising edge into a pending bank. The pending bank is promoted to the displayed bank only at a frame boundary, so markers never tear mid-frame. The block sits between the tracker and the video output mux, in the pixel-clock domain.

## Interface
- MAX_BALLS, 7, number of centroid slots (fixed by tracker interface)
- SCALE_SHIFT, 2, right-shift from video coordinates to tracker coordinates (1280x720 -> 320x180)
- MARKER_HALF, 3, marker half-size in tracker units
- FILLED, 0, 1 = solid square, 0 = one-unit-thick outline
- clk_in  in  1  pixel clock; the only clock
- rst_in  in  1  reset, asynchronous, active-low
- centroids_x_in  in  [6:0][8:0]  tracker centroid x, 0..319
- centroids_y_in  in  [6:0][7:0]  tracker centroid y, 0..179
- num_balls_in  in  3  number of valid slots, 0..7
- centroids_valid_in  in  1  tracker result-valid level; a rising edge means new results
- new_frame_in  in  1  single-cycle pulse at the first pixel of each frame
- hcount_in  in  11  video x
- vcount_in  in  10  video y
- pixel_in  in  24  RGB888 background pixel
- pixel_valid_in  in  1  hcount/vcount/pixel_in qualify this cycle
- pixel_out  out  24  composited pixel
- hit_out  out  1  pixel_out is a marker pixel
- hit_index_out  out  3  slot index of the marker drawn; 0 when hit_out=0
- pixel_valid_out  out  1  pixel_valid_in delayed 2 cycles
- shown_count_out  out  3  num_balls of the displayed bank

## Operation
- Edge detect: register centroids_valid_in as valid_q. Capture fires when centroids_valid_in=1 and valid_q=0.
- Capture copies all 7 x/y values and num_balls_in into the pending bank and sets pending_full=1. A second capture before promotion overwrites the pending bank; the last capture wins.
- Promotion: on new_frame_in with pending_full=1, pending copies to displayed and pending_full clears. With pending_full=0, the displayed bank is unchanged.
- Capture and new_frame_in in the same cycle: promotion uses the pre-capture pending contents, and the fresh capture lands in pending for the next frame. If pending was empty, no promotion happens that cycle.
- num_balls_in > 7 saturates to 7.
- Hit test per slot i < shown count:
  - px = hcount_in >> SCALE_SHIFT, py = vcount_in >> SCALE_SHIFT.
  - dx = |px − cx|, dy = |py − cy|, computed in 11-bit unsigned with compare-and-subtract (no wrap).
  - inside = dx ≤ MARKER_HALF and dy ≤ MARKER_HALF.
  - If FILLED=0, additionally require max(dx,dy) = MARKER_HALF.
  - Slots ≥ shown count never hit.
- Compositing: the lowest-index hitting slot wins. pixel_out = PALETTE[index]; otherwise pixel_out = pixel_in.
- Hit logic and compositing ignore pixel_valid_in; the block flags validity but does not gate on it.

## Timing
- Reset (asynchronous, rst_in=0): displayed and pending banks all zero, shown count 0, pending_full 0, valid_q 0. All outputs 0.
- Capture: the pending bank updates on the clock edge where the rising edge is seen.
- Promotion: the displayed bank updates at the new_frame_in edge and is used starting with the pixel presented on the following cycle. The new_frame pixel itself uses the old bank.
- Pipeline latency is exactly 2 cycles, throughput 1 pixel/cycle, no stalls:
  - Stage 1 registers the 7-bit hit vector, pixel_in and pixel_valid_in.
  - Stage 2 registers the priority encode, palette lookup and mux.
- Reset asserted mid-frame clears the pipeline immediately. Markers stay absent until a capture is followed by a new_frame_in.

## Structure
- Package overlay_pkg holds:
  - the coordinate width constants (9/8 tracker, 11/10 video);
  - MAX_BALLS;
  - the 7-entry 24-bit PALETTE constant: red, green, blue, yellow, cyan, magenta, white.
- One sub-module, marker_hit: a combinational single-slot hit test (px, py, cx, cy → hit), instantiated 7 times.
- Banks, edge detect and pipeline stay in the top module.

## Test plan
- Reset: with rst_in low, all outputs are 0. After release with no capture, pixel_in=0x123456 appears on pixel_out 2 cycles later with hit_out=0.
- Single capture: slot0=(100,50), num_balls=1, edge, then new_frame_in.
  - hcount=412 (px=103), vcount=200 (py=50): pixel_out=0xFF0000, hit_index_out=0.
  - hcount=400, vcount=200 (centre, FILLED=0): no hit.
- Tear-free: capture slot0=(200,90) mid-frame; the rest of the frame still shows the marker at (100,50). After the next new_frame_in, the marker is at (200,90).
- Overlap priority: slots 0 and 1 both at (60,60), num_balls=2. The edge pixel gives hit_index_out=0 and red.
- Simultaneous capture + new_frame_in with pending empty: shown_count_out is unchanged that frame and updates at the following new_frame_in.
- num_balls_in=3 with slot 4 at (10,10): no hit near (40,40) video. num_balls_in=7: slot 4 is drawn in cyan.
